seg_serial_tx: RTL and testbench



---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_half_timer.sv | 26 ++
 rtl/seg_serial_tx.sv | 129 ++++++++++++
 tb/tb_seg_serial_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment serial display path.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } seg_state_t;

  localparam int unsigned SEG_WIDTH  = 64;
  localparam int unsigned SEG_DIGITS = 8;

  // Bit positions of each segment within one digit byte {p,g,f,e,d,c,b,a}.
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;
  localparam int unsigned SEG_P = 7;

endpackage

// File: rtl/seg_half_timer.sv
// Serial half-period timer: counts DIV system cycles, strobes the last one.
module seg_half_timer #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_last
);

  localparam logic [7:0] LAST_CNT = 8'(DIV - 1);

  logic [7:0] r_cnt;

  // Count up within a half-period; restart clears so the next half starts at 0.
  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/seg_serial_tx.sv
// Serialises a 64-bit segment word MSB-first into a 74HC164 chain.
module seg_serial_tx
  import seg_pkg::*;
#(
  parameter int unsigned WIDTH = SEG_WIDTH,
  parameter int unsigned DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             s_clk,
  output logic             s_dat,
  output logic             s_clr_n,
  output logic             s_en
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  seg_state_t       r_state;
  seg_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    r_bitcnt;
  logic [CW-1:0]    w_bitcnt_nxt;
  logic             w_last;
  logic             w_restart;
  logic             w_shifting_nxt;
  logic             w_s_en_nxt;
  logic             r_busy;
  logic             r_done;
  logic             r_s_clk;
  logic             r_s_dat;
  logic             r_s_en;

  // Timer free-runs only inside LOW/HIGH; each half-period boundary restarts it.
  assign w_restart = !((r_state == LOW) || (r_state == HIGH)) || w_last;

  seg_half_timer #(
    .DIV(DIV)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_last    (w_last)
  );

  // Next-state, shift register and bit counter updates.
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_s_en_nxt   = r_s_en;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_shreg_nxt  = data;
          w_bitcnt_nxt = CW'(WIDTH);
          w_state_nxt  = LOW;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      LOW: begin
        if (w_last) begin
          w_state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (w_last) begin
          w_shreg_nxt  = {r_shreg[WIDTH-2:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt - CW'(1);
          w_state_nxt  = (r_bitcnt == CW'(1)) ? DONE : LOW;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_shifting_nxt = (w_state_nxt == LOW) || (w_state_nxt == HIGH);
    // Display blanks while shifting, enables on completion, otherwise holds.
    if (w_state_nxt == DONE) begin
      w_s_en_nxt = 1'b1;
    end else if (w_shifting_nxt) begin
      w_s_en_nxt = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
    end
  end

  // Pin outputs are registered from the next state so they align with the state
  // register and never glitch; s_dat tracks the MSB only on LOW entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s_clk <= 1'b0;
      r_s_dat <= 1'b0;
      r_s_en  <= 1'b0;
    end else begin
      r_busy  <= w_shifting_nxt;
      r_done  <= (w_state_nxt == DONE);
      r_s_clk <= (w_state_nxt == HIGH);
      r_s_dat <= w_shifting_nxt & w_shreg_nxt[WIDTH-1];
      r_s_en  <= w_s_en_nxt;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign s_clk   = r_s_clk;
  assign s_dat   = r_s_dat;
  assign s_clr_n = 1'b1;
  assign s_en    = r_s_en;

endmodule

// File: tb/tb_seg_serial_tx.sv
// Scoreboard bench for seg_serial_tx with DIV=2 and DIV=1 instances.
module tb_seg_serial_tx;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st2 = 1'b0;
  logic         st1 = 1'b0;
  logic [W-1:0] d2  = '0;
  logic [W-1:0] d1  = '0;
  logic busy2, done2, sclk2, sdat2, sclrn2, sen2;
  logic busy1, done1, sclk1, sdat1, sclrn1, sen1;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int           u;
    logic [W-1:0] d;
    int           dc;
  } frame_t;

  frame_t sb[$];
  int     rix[2]  = '{0, 0};
  logic   pclk[2] = '{1'b0, 1'b0};
  logic   hold[2] = '{1'b0, 1'b0};

  seg_serial_tx #(.WIDTH(W), .DIV(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .data(d2),
    .busy(busy2), .done(done2), .s_clk(sclk2), .s_dat(sdat2),
    .s_clr_n(sclrn2), .s_en(sen2)
  );

  seg_serial_tx #(.WIDTH(W), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .data(d1),
    .busy(busy1), .done(done1), .s_clk(sclk1), .s_dat(sdat1),
    .s_clr_n(sclrn1), .s_en(sen1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm, input int u);
    checks++;
    errors++;
    $display("FAIL %s: unit %0d got event expected none (cyc %0d)", nm, u, cyc);
  endtask

  // One monitor step per unit: bits checked at each s_clk rise, hold while high,
  // frame completion (timing, rise count, pin state) at each done pulse.
  task automatic mon(input int u, input logic sc, input logic sd, input logic dn,
                     input logic by, input logic se);
    logic [W-1:0] w;
    if (sc === 1'b1 && pclk[u] === 1'b0) begin
      if (sb.size() == 0 || sb[0].u != u || rix[u] >= W) begin
        bad("spurious_rise", u);
      end else begin
        w = sb[0].d;
        chk($sformatf("bit_u%0d_r%0d", u, rix[u] + 1), W'(sd), W'(w[W-1-rix[u]]));
        chk("en_busy_at_rise", W'({se, by}), W'(2'b01));
        rix[u]++;
      end
      hold[u] = sd;
    end else if (sc === 1'b1 && pclk[u] === 1'b1) begin
      chk("dat_hold_while_high", W'(sd), W'(hold[u]));
    end
    if (dn === 1'b1) begin
      if (sb.size() == 0 || sb[0].u != u) begin
        bad("spurious_done", u);
      end else begin
        chk($sformatf("done_cycle_u%0d", u), W'(cyc), W'(sb[0].dc));
        chk("rises_per_frame", W'(rix[u]), W'(W));
        chk("pins_at_done", W'({se, by, sc, sd}), W'(4'b1000));
        void'(sb.pop_front());
      end
      rix[u] = 0;
    end
    pclk[u] = sc;
  endtask

  always @(negedge clk) begin
    mon(0, sclk2, sdat2, done2, busy2, sen2);
    mon(1, sclk1, sdat1, done1, busy1, sen1);
  end

  function automatic logic [W-1:0] pack6(input logic en, input logic sc, input logic cl,
                                         input logic by, input logic dn, input logic sd);
    return W'({en, sc, cl, by, dn, sd});
  endfunction

  // Pulse start for one cycle; accepted frames go to the scoreboard with their done cycle.
  task automatic issue(input int u, input logic [W-1:0] d, input bit acc, output int k);
    frame_t f;
    if (u == 0) begin st2 = 1'b1; d2 = d; end
    else begin st1 = 1'b1; d1 = d; end
    @(posedge clk); #1;
    k = cyc;
    if (u == 0) st2 = 1'b0; else st1 = 1'b0;
    if (acc) begin
      f.u  = u;
      f.d  = d;
      f.dc = k + 2 * ((u == 0) ? 2 : 1) * W;
      sb.push_back(f);
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d frames pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int kx;

    // Reset, then idle with everything at reset values.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_pins_div2", pack6(sen2, sclk2, sclrn2, busy2, done2, sdat2), W'(6'b001000));
      chk("idle_pins_div1", pack6(sen1, sclk1, sclrn1, busy1, done1, sdat1), W'(6'b001000));
    end
    @(posedge clk); #1;

    // Single frame, plus an ignored start 10 cycles in with different data.
    issue(0, 64'h8000_0000_0000_0001, 1'b1, k);
    repeat (9) @(posedge clk);
    #1;
    chk("busy_before_ignored_start", W'(busy2), W'(1));
    issue(0, 64'h1234_5678_9ABC_DEF0, 1'b0, kx);
    d2 = 64'h0F0F_0F0F_0F0F_0F0F;
    wait_idle(400);
    @(negedge clk);
    chk("en_held_after_frame", pack6(sen2, sclk2, sclrn2, busy2, done2, sdat2),
        W'(6'b101000));
    @(posedge clk); #1;

    // Back-to-back frames with start held high.
    st2 = 1'b1;
    d2  = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    k = cyc;
    for (int i = 0; i < 3; i++) begin
      frame_t f;
      f.u  = 0;
      f.d  = 64'hFFFF_0000_FFFF_0000;
      f.dc = k + 256 + i * 257;
      sb.push_back(f);
    end
    repeat (770) @(posedge clk);
    #1 st2 = 1'b0;
    wait_idle(400);

    // Reset mid-frame at the 30th rise, then a clean frame.
    issue(0, 64'h0123_4567_89AB_CDEF, 1'b1, k);
    repeat (118) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    rix[0] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("pins_after_midframe_rst", pack6(sen2, sclk2, sclrn2, busy2, done2, sdat2),
        W'(6'b001000));
    @(posedge clk); #1;
    issue(0, 64'hFEDC_BA98_7654_3210, 1'b1, k);
    wait_idle(400);

    // DIV=1 instance.
    issue(1, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, k);
    wait_idle(300);
    @(negedge clk);
    chk("en_held_div1", W'(sen1), W'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
